// File: rtl/fighter_phys_pkg.sv
// Shared fighter physics types: state encoding, default arena/motion constants,
// and a saturating clamp used for all horizontal moves.
package fighter_phys_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_KNOCK  = 2'd2
  } fighter_state_e;

  localparam int DEF_X_MIN     = 15;
  localparam int DEF_X_MAX     = 75;
  localparam int DEF_Y_FLOOR   = 48;
  localparam int DEF_Y_CEIL    = 15;
  localparam int DEF_START_X   = 15;
  localparam int DEF_WALK_STEP = 2;
  localparam int DEF_JUMP_V    = 7;
  localparam int DEF_GRAVITY   = 1;
  localparam int DEF_VMAX_FALL = 14;
  localparam int DEF_BOUNCE_V  = 3;
  localparam int DEF_TICK_DIV  = 2500000;
  localparam int DEF_KB_TICKS  = 6;
  localparam int DEF_KB_STEP   = 3;

  function automatic int sat_clamp(input int v, input int lo, input int hi);
    int r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/fighter_kinematics_if.sv
// Control/status bundle between input decode (master) and one fighter's motion
// engine (slave); the slave's outputs feed the sprite renderer and hitbox check.
interface fighter_kinematics_if #(
  parameter int X_W = 7,
  parameter int Y_W = 7,
  parameter int V_W = 8
);
  logic                  move_left;
  logic                  move_right;
  logic                  jump;
  logic                  is_colliding;
  logic [X_W-1:0]        opp_x;
  logic [Y_W-1:0]        opp_y;
  logic                  hit_in;
  logic                  hit_dir;
  logic [X_W-1:0]        pos_x;
  logic [Y_W-1:0]        pos_y;
  logic signed [V_W-1:0] vel_y;
  logic [1:0]            state;
  logic                  tick;

  modport master (
    output move_left, move_right, jump, is_colliding, opp_x, opp_y, hit_in, hit_dir,
    input  pos_x, pos_y, vel_y, state, tick
  );

  modport slave (
    input  move_left, move_right, jump, is_colliding, opp_x, opp_y, hit_in, hit_dir,
    output pos_x, pos_y, vel_y, state, tick
  );
endinterface

// File: rtl/game_tick_divider.sv
// Game-tick divider: one-cycle strobe every TICK_DIV clocks; can be shared by
// both fighter instances so they advance in lockstep.
module game_tick_divider #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST) && !reset;

endmodule

// File: rtl/fighter_kinematics.sv
// Per-fighter motion engine: walk, gravity jump, collision block/stomp bounce and,
// with FIGHTER_KNOCKBACK_EN defined, timed knockback. State advances on game ticks only.
module fighter_kinematics
  import fighter_phys_pkg::*;
#(
  parameter int X_W       = 7,
  parameter int Y_W       = 7,
  parameter int V_W       = 8,
  parameter int X_MIN     = DEF_X_MIN,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_FLOOR   = DEF_Y_FLOOR,
  parameter int Y_CEIL    = DEF_Y_CEIL,
  parameter int START_X   = DEF_START_X,
  parameter int WALK_STEP = DEF_WALK_STEP,
  parameter int JUMP_V    = DEF_JUMP_V,
  parameter int GRAVITY   = DEF_GRAVITY,
  parameter int VMAX_FALL = DEF_VMAX_FALL,
  parameter int BOUNCE_V  = DEF_BOUNCE_V,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int KB_TICKS  = DEF_KB_TICKS,
  parameter int KB_STEP   = DEF_KB_STEP
) (
  input logic                 clk,
  input logic                 reset,
  fighter_kinematics_if.slave bus
);
  // Vertical step is evaluated two bits wider and signed so overshoot past the
  // floor or ceiling is visible before clamping.
  localparam int NY_W = Y_W + 2;
  localparam logic signed [NY_W-1:0] FLOOR_S = NY_W'(Y_FLOOR);
  localparam logic signed [NY_W-1:0] CEIL_S  = NY_W'(Y_CEIL);
  localparam logic signed [V_W:0]    VMAX_S  = (V_W+1)'(VMAX_FALL);

  logic tick;

  game_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  fighter_state_e        st_q, st_d;
  logic [X_W-1:0]        x_q, x_d, walk_x;
  logic [Y_W-1:0]        y_q, y_d, fall_y;
  logic signed [V_W-1:0] vel_q, vel_d, fall_v;
  logic signed [NY_W-1:0] ny;
  logic signed [V_W:0]   v_grav;
  logic                  landed, stomp, go_left, go_right;

`ifdef FIGHTER_KNOCKBACK_EN
  localparam int KB_W = $clog2(KB_TICKS + 1);
  logic            hit_pend_q, hit_pend_d;
  logic            hit_dir_q, hit_dir_d;
  logic            hit_now, kb_dir;
  logic [X_W-1:0]  knock_x;
  logic [KB_W-1:0] kb_q, kb_d;
`else
  localparam int unused_kb_cfg = KB_TICKS + KB_STEP;
  logic unused_hit;
  assign unused_hit = bus.hit_in ^ bus.hit_dir;
`endif

  // Walking: opposing requests cancel; moving into an overlapping opponent is blocked.
  always_comb begin
    go_left  = bus.move_left && !bus.move_right && !(bus.is_colliding && (x_q > bus.opp_x));
    go_right = bus.move_right && !bus.move_left && !(bus.is_colliding && (x_q < bus.opp_x));
    walk_x   = x_q;
    if (go_left) begin
      walk_x = X_W'(sat_clamp(int'(x_q) - WALK_STEP, X_MIN, X_MAX));
    end else if (go_right) begin
      walk_x = X_W'(sat_clamp(int'(x_q) + WALK_STEP, X_MIN, X_MAX));
    end
  end

  // Ballistic step shared by AIR and KNOCK: land, bump the ceiling, or integrate.
  always_comb begin
    ny     = $signed({2'b00, y_q}) + NY_W'(vel_q);
    v_grav = (V_W+1)'(vel_q) + (V_W+1)'(GRAVITY);
    landed = 1'b0;
    fall_y = y_q;
    fall_v = vel_q;
    if ((ny >= FLOOR_S) && !vel_q[V_W-1]) begin
      fall_y = Y_W'(Y_FLOOR);
      fall_v = '0;
      landed = 1'b1;
    end else if (ny <= CEIL_S) begin
      fall_y = Y_W'(Y_CEIL);
      fall_v = '0;
    end else begin
      fall_y = ny[Y_W-1:0];
      fall_v = (v_grav > VMAX_S) ? V_W'(VMAX_FALL) : v_grav[V_W-1:0];
    end
    stomp = bus.is_colliding && (y_q < bus.opp_y);
  end

`ifdef FIGHTER_KNOCKBACK_EN
  // A hit strobe arriving on the tick cycle itself is honoured immediately.
  always_comb begin
    hit_now = hit_pend_q || bus.hit_in;
    kb_dir  = bus.hit_in ? bus.hit_dir : hit_dir_q;
    knock_x = kb_dir ? X_W'(sat_clamp(int'(x_q) + KB_STEP, X_MIN, X_MAX))
                     : X_W'(sat_clamp(int'(x_q) - KB_STEP, X_MIN, X_MAX));
  end
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    y_d   = y_q;
    vel_d = vel_q;
`ifdef FIGHTER_KNOCKBACK_EN
    hit_pend_d = hit_pend_q;
    hit_dir_d  = hit_dir_q;
    kb_d       = kb_q;
    if (bus.hit_in) begin
      hit_pend_d = 1'b1;
      hit_dir_d  = bus.hit_dir;
    end
`endif
    if (tick) begin
`ifdef FIGHTER_KNOCKBACK_EN
      hit_pend_d = 1'b0;
`endif
      case (st_q)
        ST_GROUND: begin
          x_d = walk_x;
          if (bus.jump) begin
            vel_d = V_W'(-JUMP_V);
            st_d  = ST_AIR;
          end
        end
        ST_AIR: begin
          x_d = walk_x;
          if (stomp) begin
            vel_d = V_W'(-BOUNCE_V);
          end else begin
            y_d   = fall_y;
            vel_d = fall_v;
            if (landed) st_d = ST_GROUND;
          end
        end
`ifdef FIGHTER_KNOCKBACK_EN
        ST_KNOCK: begin
          x_d   = knock_x;
          y_d   = fall_y;
          vel_d = fall_v;
          kb_d  = kb_q - 1'b1;
          if (kb_q <= KB_W'(1)) begin
            st_d = (fall_y == Y_W'(Y_FLOOR)) ? ST_GROUND : ST_AIR;
          end
        end
`endif
        default: st_d = ST_GROUND;
      endcase
`ifdef FIGHTER_KNOCKBACK_EN
      // A pending hit beats any walk/jump and re-arms a knockback already running.
      if (hit_now) begin
        st_d  = ST_KNOCK;
        kb_d  = KB_W'(KB_TICKS);
        x_d   = knock_x;
        y_d   = fall_y;
        vel_d = fall_v;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= ST_GROUND;
      x_q   <= X_W'(START_X);
      y_q   <= Y_W'(Y_FLOOR);
      vel_q <= '0;
`ifdef FIGHTER_KNOCKBACK_EN
      hit_pend_q <= 1'b0;
      hit_dir_q  <= 1'b0;
      kb_q       <= '0;
`endif
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      y_q   <= y_d;
      vel_q <= vel_d;
`ifdef FIGHTER_KNOCKBACK_EN
      hit_pend_q <= hit_pend_d;
      hit_dir_q  <= hit_dir_d;
      kb_q       <= kb_d;
`endif
    end
  end

  assign bus.pos_x = x_q;
  assign bus.pos_y = y_q;
  assign bus.vel_y = vel_q;
  assign bus.state = st_q;
  assign bus.tick  = tick;

endmodule
